rv_instr_encoder_loader: RTL and testbench

Streaming encoder for the single-cycle RV32I core. It accepts symbolic instruction fields (type, rd, rs1, rs2, funct3, funct7[5], imm) over a valid/ready handshake. It packs them into 32-bit R/I/L/S machine words, using the exact encodings the core's control unit decodes. It writes each word into instruction memory at an auto-incrementing word address. It is used by the bring-up path and the testbench to load programs without a hex file.

---
 rtl/rv_pkg.sv | 31 +++
 rtl/rv_instr_pack.sv | 54 +++++
 rtl/rv_instr_encoder_loader.sv | 123 ++++++++++++
 tb/tb_rv_instr_encoder_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and encoding constants for the RV32I instruction encoder/loader.
package rv_pkg;

  // Symbolic instruction format selector.
  typedef enum logic [1:0] {
    T_R = 2'd0,
    T_I = 2'd1,
    T_L = 2'd2,
    T_S = 2'd3
  } instr_type_e;

  // Loader session state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } load_state_e;

  // Opcodes exactly as the core's control unit decodes them.
  localparam logic [6:0] OP_TYPE_R = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I = 7'b0010011;
  localparam logic [6:0] OP_TYPE_L = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S = 7'b0100011;

  // funct3 values with special meaning to the encoder.
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_W      = 3'b010;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational packer: symbolic fields -> 32-bit RV32I word plus an illegal flag.
module rv_instr_pack
  import rv_pkg::*;
(
  input  logic [1:0]  i_type,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic        i_f7b5,
  input  logic [11:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic w_is_shift;

  assign w_is_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);

  // Select the bit layout for the requested format and flag unsupported combinations.
  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (instr_type_e'(i_type))
      T_R: begin
        o_word    = {1'b0, i_f7b5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, OP_TYPE_R};
        // Only sub (000) and sra (101) have funct7[5] set.
        o_illegal = i_f7b5 && (i_funct3 != F3_ADDSUB) && (i_funct3 != F3_SR);
      end
      T_I: begin
        if (w_is_shift) begin
          o_word = {1'b0, i_f7b5, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_TYPE_I};
        end else begin
          o_word = {i_imm, i_rs1, i_funct3, i_rd, OP_TYPE_I};
        end
        // There is no arithmetic left shift.
        o_illegal = (i_funct3 == F3_SLL) && i_f7b5;
      end
      T_L: begin
        o_word    = {i_imm, i_rs1, F3_W, i_rd, OP_TYPE_L};
        o_illegal = (i_funct3 != F3_W);
      end
      T_S: begin
        o_word    = {i_imm[11:5], i_rs2, i_rs1, F3_W, i_imm[4:0], OP_TYPE_S};
        o_illegal = (i_funct3 != F3_W);
      end
      default: begin
        o_word    = '0;
        o_illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Streaming instruction encoder that writes packed words into instruction memory.
module rv_instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_type,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [2:0]                    in_funct3,
  input  logic                          in_f7b5,
  input  logic [11:0]                   in_imm,
  input  logic                          in_last,
  output logic                          imem_we,
  output logic [ADDR_W-1:0]             imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          busy,
  output logic                          load_done,
  output logic                          err_illegal,
  output logic [$clog2(IMEM_DEPTH):0]   word_count
);

  localparam int CW = $clog2(IMEM_DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  load_state_e       r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CW-1:0]     r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_xfer;
  logic [31:0]       w_word;
  logic              w_illegal;

  rv_instr_pack u_pack (
    .i_type    (in_type),
    .i_rd      (in_rd),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_funct3  (in_funct3),
    .i_f7b5    (in_f7b5),
    .i_imm     (in_imm),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The word count is updated on the transfer edge, so no separate pending term is needed.
  assign w_ready = (r_state == ST_LOAD) && (r_count < DEPTH_C);
  assign w_xfer  = in_valid && w_ready;

  // Session FSM with registered write port and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= BASE_C;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE_C;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_ptr   <= BASE_C;
            r_count <= '0;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr;
              r_wdata <= w_word;
              r_ptr   <= r_ptr + ADDR_W'(4);
              r_count <= r_count + CW'(1);
            end
            // Session ends on the marked last word or when memory is full.
            if (in_last || (!w_illegal && (r_count + CW'(1) == DEPTH_C))) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign busy        = (r_state == ST_LOAD);
  assign load_done   = r_done;
  assign err_illegal = r_err;
  assign word_count  = r_count;

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// Self-checking bench: behavioural model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_rv_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_type = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic          in_f7b5 = 1'b0;
  logic [11:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, load_done, err_illegal;
  logic [CW-1:0] word_count;

  rv_instr_encoder_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(0), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .load_done(load_done), .err_illegal(err_illegal), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int          log_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  bit          model_on = 0;
  int          m_phase  = 0;   // 0 idle, 1 loading, 2 finishing
  int          m_count  = 0;
  logic [31:0] m_ptr    = 0;
  logic        e_we = 0, e_err = 0, e_done = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;

  function automatic void model_enc(input int t, input logic [31:0] rd, rs1, rs2, f3, f7, imm,
                                    output logic [31:0] w, output bit ill);
    case (t)
      0: begin
        w   = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        ill = (f7 == 1) && !(f3 == 0 || f3 == 5);
      end
      1: begin
        if (f3 == 1 || f3 == 5) w = (f7 << 30) | ((imm % 32) << 20);
        else                    w = imm << 20;
        w   = w | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        ill = (f3 == 1) && (f7 == 1);
      end
      2: begin
        w   = (imm << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
        ill = (f3 != 2);
      end
      default: begin
        w   = ((imm / 32) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) | ((imm % 32) << 7) | 32'h23;
        ill = (f3 != 2);
      end
    endcase
  endfunction

  // Advance the model on each rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    logic [31:0] w;
    bit ill;
    cyc++;
    if (reset) begin
      model_on = 1;
      m_phase = 0; m_count = 0; m_ptr = 0;
      e_we = 0; e_err = 0; e_done = 0; e_addr = 0; e_wdata = 0;
    end else begin
      e_we = 0; e_err = 0; e_done = 0;
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_count = 0; m_ptr = 0; end
      end else if (m_phase == 1) begin
        if (in_valid && m_count < DEPTH) begin
          model_enc(int'(in_type), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), 32'(in_funct3),
                    32'(in_f7b5), 32'(in_imm), w, ill);
          if (ill) e_err = 1;
          else begin
            e_we = 1; e_addr = m_ptr; e_wdata = w; m_ptr += 4; m_count++;
          end
          if (in_last || m_count == DEPTH) m_phase = 2;
        end
      end else begin
        e_done = 1; m_phase = 0;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("imem_we", 32'(imem_we), 32'(e_we));
      chk("imem_addr", imem_addr, e_addr);
      chk("imem_wdata", imem_wdata, e_wdata);
      chk("err_illegal", 32'(err_illegal), 32'(e_err));
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("in_ready", 32'(in_ready), 32'((m_phase == 1) && (m_count < DEPTH)));
      chk("word_count", 32'(word_count), 32'(m_count));
      if (imem_we === 1'b1) begin log_a.push_back(imem_addr); log_d.push_back(imem_wdata); log_c.push_back(cyc); end
      if (load_done === 1'b1) done_cnt++;
      if (err_illegal === 1'b1) err_cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic clear_log();
    log_a.delete(); log_d.delete(); log_c.delete();
  endtask

  task automatic do_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int t, input int rd, input int rs1, input int rs2, input int f3,
                      input int f7, input int imm, input bit last, input bit expect_accept);
    bit acc = 0;
    in_type = 2'(t); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_f7b5 = 1'(f7); in_imm = 12'(imm); in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 6 && !acc; k++) begin
      acc = (in_ready === 1'b1);
      @(negedge clk);
    end
    if (acc != expect_accept) begin
      n_checks++;
      $display("FAIL handshake: accepted=%0d expected=%0d (cycle %0d)", acc, expect_accept, cyc);
    end
    if (!expect_accept) begin in_valid = 1'b0; in_last = 1'b0; end
  endtask

  task automatic chk_log(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < log_a.size()) begin
      chk("log_addr", log_a[idx], a);
      chk("log_data", log_d[idx], d);
    end else begin
      n_checks++;
      $display("FAIL log_entry: write %0d missing, got %0d writes", idx, log_a.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, e0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);

    // add x3,x1,x2
    clear_log(); do_start();
    send(0, 3, 1, 2, 0, 0, 0, 1, 1); idle(3);
    chk("n_writes_add", log_a.size(), 1);
    chk_log(0, 32'h0, 32'h002081B3);

    // sub, srai, addi back to back
    clear_log(); do_start();
    send(0, 5, 6, 7, 0, 1, 0, 0, 1);
    send(1, 4, 4, 0, 5, 1, 3, 0, 1);
    send(1, 1, 0, 0, 0, 0, 12'hFFF, 1, 1); idle(3);
    chk_log(0, 32'h0, 32'h407302B3);
    chk_log(1, 32'h4, 32'h40325213);
    chk_log(2, 32'h8, 32'hFFF00093);
    if (log_c.size() == 3) begin
      chk("b2b_gap1", log_c[1] - log_c[0], 1);
      chk("b2b_gap2", log_c[2] - log_c[1], 1);
    end

    // sw then lw, last
    clear_log(); d0 = done_cnt; do_start();
    send(3, 0, 1, 2, 2, 0, 8, 0, 1);
    send(2, 5, 1, 0, 2, 0, 4, 1, 1); idle(3);
    chk_log(0, 32'h0, 32'h0020A423);
    chk_log(1, 32'h4, 32'h0040A283);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after", 32'(busy), 32'h0);
    chk("count_after", 32'(word_count), 32'd2);

    // illegal lw (f3=000) between two legal words
    clear_log(); e0 = err_cnt; do_start();
    send(0, 3, 1, 2, 0, 0, 0, 0, 1);
    send(2, 5, 1, 0, 0, 0, 4, 0, 1);
    send(1, 1, 0, 0, 0, 0, 12'hFFF, 1, 1); idle(3);
    chk("err_pulses", err_cnt - e0, 1);
    chk("n_writes_ill", log_a.size(), 2);
    chk_log(1, 32'h4, 32'hFFF00093);

    // capacity: five offered, four accepted
    clear_log(); d0 = done_cnt; do_start();
    for (int i = 0; i < 4; i++) send(1, i + 1, 0, 0, 0, 0, i, 0, 1);
    send(1, 9, 0, 0, 0, 0, 9, 0, 0); idle(3);
    chk("cap_writes", log_a.size(), 4);
    chk_log(3, 32'hC, 32'h00300213);
    chk("cap_done", done_cnt - d0, 1);

    // start together with in_valid: no transfer that cycle
    clear_log();
    start = 1'b1; in_valid = 1'b1; in_type = 2'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_funct3 = 3'd0; in_f7b5 = 1'b0; in_last = 1'b1;
    chk("start_ready", 32'(in_ready), 32'h0);
    @(negedge clk); start = 1'b0;
    send(0, 3, 1, 2, 0, 0, 0, 1, 1); idle(3);
    chk("start_writes", log_a.size(), 1);

    // reset coincident with a transfer discards the write
    clear_log(); do_start();
    in_type = 2'd0; in_rd = 5'd7; in_f7b5 = 1'b0; in_funct3 = 3'd0; in_last = 1'b0;
    in_valid = 1'b1; reset = 1'b1;
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    idle(2);
    chk("rst_nowrite", log_a.size(), 0);
    do_start(); send(0, 3, 1, 2, 0, 0, 0, 1, 1); idle(3);
    chk_log(0, 32'h0, 32'h002081B3);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 7) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_type   = 2'($urandom_range(0, 3));
      in_rd     = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_f7b5   = 1'($urandom);
      in_imm    = 12'($urandom);
      in_funct3 = ($urandom_range(0, 3) == 0 || in_type < 2) ? 3'($urandom) : 3'd2;
      in_last   = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
